// File: rtl/bus_block_copy.sv
// Bus initiator that copies a run of 16-bit words between byte-addressed regions,
// or fills a region with a constant, one request/acknowledge transaction at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for iStart; operands latched on accept
// S_RD_REQ | one idle bus cycle, then read request at src until iACK
// S_WR_REQ | one idle bus cycle, then write request at dst until iACK
// S_DONE   | oDone pulse with oErr=0, then back to idle
// S_ERR    | oDone pulse with oErr=1 after a request timed out
module bus_block_copy #(
  parameter int ADDR_W  = 20,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic              iMode,
  input  logic [ADDR_W-1:0] iSrc_addr,
  input  logic [ADDR_W-1:0] iDst_addr,
  input  logic [LEN_W-1:0]  iLen_words,
  input  logic [15:0]       iFill,
  input  logic              iACK,
  input  logic [15:0]       iData,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oBus_en,
  output logic [1:0]        oByte_en,
  output logic              oRd_Nwr,
  output logic [15:0]       oData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]     TMR_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_WR_REQ, S_DONE, S_ERR} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  src_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [LEN_W-1:0]   rem_q;
  logic               mode_q;
  logic [15:0]        fill_q;
  logic [15:0]        data_q;
  logic [TW-1:0]      tmr_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      mode_q   <= 1'b0;
      fill_q   <= '0;
      data_q   <= '0;
      tmr_q    <= '0;
      oAddr    <= '0;
      oBus_en  <= 1'b0;
      oByte_en <= 2'b00;
      oRd_Nwr  <= 1'b0;
      oData    <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iStart) begin
            src_q  <= iSrc_addr;
            dst_q  <= iDst_addr;
            rem_q  <= iLen_words;
            mode_q <= iMode;
            fill_q <= iFill;
            oBusy  <= 1'b1;
            if (iLen_words == '0) begin
              oDone <= 1'b1;
              state <= S_DONE;
            end else if (iMode) begin
              state <= S_WR_REQ;
            end else begin
              state <= S_RD_REQ;
            end
          end
        end

        // Entering a request state always leaves the bus idle for one cycle first.
        S_RD_REQ: begin
          if (!oBus_en) begin
            oBus_en  <= 1'b1;
            oByte_en <= 2'b11;
            oRd_Nwr  <= 1'b1;
            oAddr    <= src_q;
            tmr_q    <= TMR_LOAD;
          end else if (iACK) begin
            oBus_en  <= 1'b0;
            oByte_en <= 2'b00;
            data_q   <= iData;
            src_q    <= src_q + ADDR_STEP;
            state    <= S_WR_REQ;
          end else if (tmr_q == '0) begin
            oBus_en  <= 1'b0;
            oByte_en <= 2'b00;
            oDone    <= 1'b1;
            oErr     <= 1'b1;
            state    <= S_ERR;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end

        S_WR_REQ: begin
          if (!oBus_en) begin
            oBus_en  <= 1'b1;
            oByte_en <= 2'b11;
            oRd_Nwr  <= 1'b0;
            oAddr    <= dst_q;
            oData    <= mode_q ? fill_q : data_q;
            tmr_q    <= TMR_LOAD;
          end else if (iACK) begin
            oBus_en  <= 1'b0;
            oByte_en <= 2'b00;
            dst_q    <= dst_q + ADDR_STEP;
            rem_q    <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              oDone <= 1'b1;
              state <= S_DONE;
            end else if (mode_q) begin
              state <= S_WR_REQ;
            end else begin
              state <= S_RD_REQ;
            end
          end else if (tmr_q == '0) begin
            oBus_en  <= 1'b0;
            oByte_en <= 2'b00;
            oDone    <= 1'b1;
            oErr     <= 1'b1;
            state    <= S_ERR;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end

        S_DONE, S_ERR: begin
          oDone <= 1'b0;
          oErr  <= 1'b0;
          oBusy <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_block_copy.sv
// Directed bench for bus_block_copy: a behavioural responder acknowledges requests
// after a programmable delay and logs every completed transaction.
module tb_bus_block_copy;

  localparam int ADDR_W  = 20;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 8;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic              iStart = 1'b0;
  logic              iMode = 1'b0;
  logic [ADDR_W-1:0] iSrc_addr = '0;
  logic [ADDR_W-1:0] iDst_addr = '0;
  logic [LEN_W-1:0]  iLen_words = '0;
  logic [15:0]       iFill = '0;
  logic              iACK = 1'b0;
  logic [15:0]       iData = '0;
  logic [ADDR_W-1:0] oAddr;
  logic              oBus_en;
  logic [1:0]        oByte_en;
  logic              oRd_Nwr;
  logic [15:0]       oData;
  logic              oBusy;
  logic              oDone;
  logic              oErr;

  always #5 iCLK = ~iCLK;

  bus_block_copy #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iMode(iMode),
    .iSrc_addr(iSrc_addr), .iDst_addr(iDst_addr), .iLen_words(iLen_words),
    .iFill(iFill), .iACK(iACK), .iData(iData),
    .oAddr(oAddr), .oBus_en(oBus_en), .oByte_en(oByte_en), .oRd_Nwr(oRd_Nwr),
    .oData(oData), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Responder controls (written by tests) and observation state (written by responder only)
  bit  resp_on    = 1'b0;
  int  resp_delay = 0;
  int  wait_cnt   = 0;
  int  low_run    = 0;
  bit  prev_en    = 1'b0;
  int  en_cycles  = 0;
  int  stable_err = 0;
  int  rd_idx     = 0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic              hold_rd   = 1'b0;
  logic [15:0]       hold_data = '0;
  logic [15:0] rd_table [0:3] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [ADDR_W-1:0] log_addr [$];
  logic              log_rd   [$];
  logic [15:0]       log_data [$];
  int                gap_q    [$];

  always @(negedge iCLK) begin
    if (iRST) begin
      iACK    = 1'b0;
      prev_en = 1'b0;
      low_run = 0;
    end else if (oBus_en) begin
      en_cycles++;
      if (!prev_en) begin
        gap_q.push_back(low_run);
        wait_cnt = 0;
      end else if (oAddr !== hold_addr || oRd_Nwr !== hold_rd || oData !== hold_data) begin
        stable_err++;
      end
      if (oByte_en !== 2'b11) stable_err++;
      hold_addr = oAddr;
      hold_rd   = oRd_Nwr;
      hold_data = oData;
      if (resp_on && wait_cnt == resp_delay) begin
        iACK = 1'b1;
        if (oRd_Nwr) begin
          iData = rd_table[rd_idx % 4];
          rd_idx++;
        end
        log_addr.push_back(oAddr);
        log_rd.push_back(oRd_Nwr);
        log_data.push_back(oRd_Nwr ? iData : oData);
      end else begin
        iACK = 1'b0;
      end
      wait_cnt++;
      low_run = 0;
      prev_en = 1'b1;
    end else begin
      iACK = 1'b0;
      low_run++;
      prev_en = 1'b0;
    end
  end

  task automatic start_op(input logic mode, input logic [ADDR_W-1:0] src,
                          input logic [ADDR_W-1:0] dst, input logic [LEN_W-1:0] len,
                          input logic [15:0] fill);
    @(negedge iCLK);
    iMode = mode; iSrc_addr = src; iDst_addr = dst; iLen_words = len; iFill = fill;
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output logic err);
    seen = 1'b0;
    err  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge iCLK);
      if (oDone) begin
        seen = 1'b1;
        err  = oErr;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge iCLK);
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    idle(3);
    n_checks++;
    if ({oAddr, oBus_en, oByte_en, oRd_Nwr, oData, oBusy, oDone, oErr} !== '0)
      $display("FAIL reset_outputs: got addr=%h en=%b be=%b rd=%b data=%h busy=%b done=%b err=%b, want all zero",
               oAddr, oBus_en, oByte_en, oRd_Nwr, oData, oBusy, oDone, oErr);
    else n_pass++;
    iRST = 1'b0;
    idle(2);
  endtask

  task automatic test_copy();
    logic [ADDR_W-1:0] exp_addr [0:7] = '{20'h00100, 20'h00200, 20'h00102, 20'h00202,
                                          20'h00104, 20'h00204, 20'h00106, 20'h00206};
    logic [15:0] exp_data [0:7] = '{16'h1111, 16'h1111, 16'h2222, 16'h2222,
                                    16'h3333, 16'h3333, 16'h4444, 16'h4444};
    int  base  = log_addr.size();
    int  gbase = gap_q.size();
    int  sbase = stable_err;
    bit  seen;
    logic err;
    resp_on = 1'b1; resp_delay = 2;
    start_op(1'b0, 20'h00100, 20'h00200, 16'd4, 16'h0000);
    wait_done(300, seen, err);
    n_checks++;
    if (!seen || err !== 1'b0) $display("FAIL copy_done: seen=%b err=%b, want seen=1 err=0", seen, err);
    else n_pass++;
    n_checks++;
    if (log_addr.size() - base !== 8) $display("FAIL copy_count: got %0d transactions, want 8", log_addr.size() - base);
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (log_addr[base+i] !== exp_addr[i] || log_rd[base+i] !== ((i % 2) == 0) || log_data[base+i] !== exp_data[i])
          $display("FAIL copy_txn%0d: got addr=%h rd=%b data=%h, want addr=%h rd=%b data=%h", i,
                   log_addr[base+i], log_rd[base+i], log_data[base+i], exp_addr[i], (i % 2) == 0, exp_data[i]);
        else n_pass++;
      end
    end
    for (int i = gbase + 1; i < gap_q.size(); i++) begin
      n_checks++;
      if (gap_q[i] !== 1) $display("FAIL copy_gap%0d: got %0d idle cycles, want 1", i - gbase, gap_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (stable_err !== sbase) $display("FAIL copy_stable: got %0d unstable cycles, want 0", stable_err - sbase);
    else n_pass++;
    @(negedge iCLK);
    n_checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) $display("FAIL copy_after: got done=%b busy=%b, want 0 0", oDone, oBusy);
    else n_pass++;
  endtask

  task automatic test_fill();
    int  base = log_addr.size();
    bit  seen;
    logic err;
    resp_on = 1'b1; resp_delay = 0;
    start_op(1'b1, 20'h00000, 20'h00010, 16'd3, 16'hBEEF);
    wait_done(200, seen, err);
    n_checks++;
    if (!seen || err !== 1'b0) $display("FAIL fill_done: seen=%b err=%b, want seen=1 err=0", seen, err);
    else n_pass++;
    n_checks++;
    if (log_addr.size() - base !== 3) $display("FAIL fill_count: got %0d transactions, want 3", log_addr.size() - base);
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (log_addr[base+i] !== 20'h00010 + 20'(2*i) || log_rd[base+i] !== 1'b0 || log_data[base+i] !== 16'hBEEF)
          $display("FAIL fill_txn%0d: got addr=%h rd=%b data=%h, want addr=%h rd=0 data=beef", i,
                   log_addr[base+i], log_rd[base+i], log_data[base+i], 20'h00010 + 20'(2*i));
        else n_pass++;
      end
    end
    idle(2);
  endtask

  task automatic test_zero_len();
    int ebase = en_cycles;
    @(negedge iCLK);
    iMode = 1'b0; iSrc_addr = 20'h00500; iDst_addr = 20'h00600; iLen_words = '0; iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    n_checks++;
    if (oDone !== 1'b1 || oErr !== 1'b0) $display("FAIL zero_done: got done=%b err=%b, want 1 0", oDone, oErr);
    else n_pass++;
    idle(3);
    n_checks++;
    if (en_cycles !== ebase || oBusy !== 1'b0)
      $display("FAIL zero_bus: got %0d request cycles busy=%b, want 0 0", en_cycles - ebase, oBusy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int  ebase = en_cycles;
    bit  seen;
    logic err;
    resp_on = 1'b0;
    start_op(1'b1, 20'h00000, 20'h00040, 16'd2, 16'h5A5A);
    wait_done(100, seen, err);
    n_checks++;
    if (!seen || err !== 1'b1) $display("FAIL timeout_err: seen=%b err=%b, want seen=1 err=1", seen, err);
    else n_pass++;
    n_checks++;
    if (en_cycles - ebase !== TIMEOUT || oBus_en !== 1'b0)
      $display("FAIL timeout_len: got %0d request cycles en=%b, want %0d 0", en_cycles - ebase, oBus_en, TIMEOUT);
    else n_pass++;
    @(negedge iCLK);
    n_checks++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oErr !== 1'b0)
      $display("FAIL timeout_after: got busy=%b done=%b err=%b, want 0 0 0", oBusy, oDone, oErr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int  base = log_addr.size();
    bit  seen;
    logic err;
    resp_on = 1'b1; resp_delay = 1;
    start_op(1'b1, 20'h00000, 20'hFFFFE, 16'd2, 16'h1234);
    wait_done(100, seen, err);
    n_checks++;
    if (!seen || err !== 1'b0 || log_addr.size() - base !== 2)
      $display("FAIL wrap_done: seen=%b err=%b txns=%0d, want 1 0 2", seen, err, log_addr.size() - base);
    else begin
      n_pass++;
      n_checks++;
      if (log_addr[base] !== 20'hFFFFE || log_addr[base+1] !== 20'h00000 || log_data[base+1] !== 16'h1234)
        $display("FAIL wrap_addr: got %h then %h data=%h, want fffff/e then 00000 data=1234",
                 log_addr[base], log_addr[base+1], log_data[base+1]);
      else n_pass++;
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int  base = log_addr.size();
    int  dcnt = 0;
    bit  ok;
    resp_on = 1'b1; resp_delay = 1;
    start_op(1'b1, 20'h00000, 20'h00300, 16'd4, 16'hAAAA);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge iCLK);
      if (log_addr.size() > base) ok = 1'b1;
    end
    resp_delay = 20;
    iMode = 1'b0; iSrc_addr = 20'h00800; iDst_addr = 20'h00900; iLen_words = 16'd1; iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    for (int i = 0; i < 20 && !oBus_en; i++) @(negedge iCLK);
    n_checks++;
    if (!ok || oBus_en !== 1'b1 || oAddr !== 20'h00302 || oRd_Nwr !== 1'b0 || oData !== 16'hAAAA)
      $display("FAIL busy_start_ignored: got ok=%b en=%b addr=%h rd=%b data=%h, want 1 1 00302 0 aaaa",
               ok, oBus_en, oAddr, oRd_Nwr, oData);
    else n_pass++;
    iRST = 1'b1;
    @(negedge iCLK);
    n_checks++;
    if ({oAddr, oBus_en, oByte_en, oRd_Nwr, oData, oBusy, oDone, oErr} !== '0)
      $display("FAIL reset_mid: got addr=%h en=%b be=%b rd=%b data=%h busy=%b done=%b err=%b, want all zero",
               oAddr, oBus_en, oByte_en, oRd_Nwr, oData, oBusy, oDone, oErr);
    else n_pass++;
    iRST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge iCLK);
      if (oDone || oBus_en) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0) $display("FAIL reset_quiet: got %0d cycles with done/request, want 0", dcnt);
    else n_pass++;
    @(negedge iCLK);
    iLen_words = '0; iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    n_checks++;
    if (oDone !== 1'b1 || oErr !== 1'b0) $display("FAIL reset_idle: got done=%b err=%b, want 1 0", oDone, oErr);
    else n_pass++;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_zero_len();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
